// File: rtl/csr_timer.sv
// csr_timer: constant timer (TCFG/TVAL/TICLR) and 64-bit stable counter with level timer interrupt.
module csr_timer #(
  parameter int          TIMER_W    = 32,
  parameter logic [13:0] TCFG_ADDR  = 14'h41,
  parameter logic [13:0] TVAL_ADDR  = 14'h42,
  parameter logic [13:0] TICLR_ADDR = 14'h44
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               csr_we,
  input  logic [13:0]        csr_waddr,
  input  logic [31:0]        csr_wdata,
  output logic [TIMER_W-1:0] tcfg_q,
  output logic [TIMER_W-1:0] tval_q,
  output logic               timer_int,
  output logic [63:0]        cnt_q
);
  logic               run;
  logic               tcfg_wr;
  logic               ticlr_wr;
  logic               expire;
  logic [TIMER_W-1:0] reload;
  // TVAL is read-only, so a write decoding to it never updates TCFG even if the numbers were aliased
  assign tcfg_wr  = csr_we && csr_waddr == TCFG_ADDR && csr_waddr != TVAL_ADDR;
  assign ticlr_wr = csr_we && csr_waddr == TICLR_ADDR && csr_wdata[0];
  assign expire   = run && !tcfg_wr && tval_q == '0;
  assign reload   = {tcfg_q[TIMER_W-1:2], 2'b00};
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tcfg_q    <= '0;
      tval_q    <= '1;
      timer_int <= 1'b0;
      cnt_q     <= '0;
      run       <= 1'b0;
    end else begin
      cnt_q     <= cnt_q + 64'd1;
      timer_int <= expire | (timer_int & ~ticlr_wr);
      if (tcfg_wr) begin
        tcfg_q <= csr_wdata[TIMER_W-1:0];
        tval_q <= {csr_wdata[TIMER_W-1:2], 2'b00};
        run    <= csr_wdata[0];
      end else if (run) begin
        tval_q <= expire ? (tcfg_q[1] ? reload : '1) : tval_q - TIMER_W'(1);
        run    <= !expire || tcfg_q[1];
      end
    end
  end
endmodule

// File: tb/tb_csr_timer.sv
// tb_csr_timer: scoreboard bench for csr_timer; expectations queued with stimulus, popped per cycle.
module tb_csr_timer;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        csr_we = 1'b0;
  logic [13:0] csr_waddr = '0;
  logic [31:0] csr_wdata = '0;
  logic [31:0] tcfg_q;
  logic [31:0] tval_q;
  logic        timer_int;
  logic [63:0] cnt_q;
  int total = 0;
  int bad = 0;
  typedef struct {int at; int sel; logic [63:0] val; string nm;} exp_t;
  typedef struct {int at; logic [13:0] a; logic [31:0] d;} stim_t;
  exp_t  sb[$];
  stim_t st[$];
  exp_t  e;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF;
  csr_timer dut (
    .clk(clk), .resetn(resetn), .csr_we(csr_we), .csr_waddr(csr_waddr),
    .csr_wdata(csr_wdata), .tcfg_q(tcfg_q), .tval_q(tval_q),
    .timer_int(timer_int), .cnt_q(cnt_q)
  );
  always #5 clk = ~clk;
  function automatic logic [63:0] obs(int sel);
    return sel == 0 ? {32'b0, tcfg_q} : sel == 1 ? {32'b0, tval_q} :
           sel == 2 ? {63'b0, timer_int} : cnt_q;
  endfunction
  function automatic void ex(int at, int sel, logic [63:0] v, string nm);
    sb.push_back('{at, sel, v, nm});
  endfunction
  function automatic void wr(int at, logic [13:0] a, logic [31:0] d);
    st.push_back('{at, a, d});
  endfunction
  task automatic drive(int n);
    if (st.size() > 0 && st[0].at == n) begin
      csr_we = 1'b1;
      csr_waddr = st[0].a;
      csr_wdata = st[0].d;
      void'(st.pop_front());
    end else begin
      csr_we = 1'b0;
    end
  endtask
  task automatic test_reset;
    ex(0, 0, 0, "rst_tcfg"); ex(0, 1, ONES, "rst_tval");
    ex(0, 2, 0, "rst_int");  ex(0, 3, 0, "rst_cnt");
    for (int i = 1; i <= 4; i++) ex(i, 3, 64'(i), "cnt_inc");
    for (int k = 0; k <= 4; k++) begin
      while (sb.size() > 0 && sb[0].at == k) begin
        e = sb.pop_front();
        total++;
        if (obs(e.sel) !== e.val) begin
          bad++;
          $display("FAIL %s k=%0d got=%h exp=%h", e.nm, k, obs(e.sel), e.val);
        end
      end
      drive(k + 1);
      @(negedge clk);
    end
  endtask
  task automatic test_periodic;
    wr(0, 14'h41, 32'h13); wr(35, 14'h44, 32'h1); wr(52, 14'h44, 32'h2); wr(68, 14'h44, 32'h1);
    ex(0, 0, 64'h13, "per_tcfg"); ex(0, 1, 64'h10, "per_load"); ex(0, 2, 0, "per_int0");
    ex(1, 1, 64'h0F, "per_dec");
    ex(16, 1, 0, "per_zero"); ex(16, 2, 0, "per_int_pre");
    ex(17, 2, 1, "per_ti1"); ex(17, 1, 64'h10, "per_reload1");
    ex(33, 1, 0, "per_zero2");
    ex(34, 2, 1, "per_ti2"); ex(34, 1, 64'h10, "per_reload2");
    ex(35, 2, 0, "ticlr_clr"); ex(35, 1, 64'h0F, "ticlr_count");
    ex(50, 1, 0, "per_zero3"); ex(50, 2, 0, "ticlr_hold");
    ex(51, 2, 1, "per_ti3");
    ex(52, 2, 1, "ticlr_bit0_0");
    ex(68, 2, 1, "ticlr_vs_set"); ex(68, 1, 64'h10, "per_reload4");
    ex(69, 2, 1, "ticlr_vs_set2");
    for (int k = -1; k <= 69; k++) begin
      while (sb.size() > 0 && sb[0].at == k) begin
        e = sb.pop_front();
        total++;
        if (obs(e.sel) !== e.val) begin
          bad++;
          $display("FAIL %s k=%0d got=%h exp=%h", e.nm, k, obs(e.sel), e.val);
        end
      end
      drive(k + 1);
      @(negedge clk);
    end
  endtask
  task automatic test_oneshot;
    wr(0, 14'h44, 32'h1); wr(1, 14'h41, 32'h11);
    ex(0, 2, 0, "os_clr");
    ex(1, 0, 64'h11, "os_tcfg"); ex(1, 1, 64'h10, "os_load");
    ex(17, 1, 0, "os_zero"); ex(17, 2, 0, "os_int_pre");
    ex(18, 2, 1, "os_ti"); ex(18, 1, ONES, "os_ones");
    ex(40, 1, ONES, "os_hold"); ex(68, 1, ONES, "os_hold50"); ex(68, 2, 1, "os_int_level");
    for (int k = -1; k <= 68; k++) begin
      while (sb.size() > 0 && sb[0].at == k) begin
        e = sb.pop_front();
        total++;
        if (obs(e.sel) !== e.val) begin
          bad++;
          $display("FAIL %s k=%0d got=%h exp=%h", e.nm, k, obs(e.sel), e.val);
        end
      end
      drive(k + 1);
      @(negedge clk);
    end
  endtask
  task automatic test_disable;
    wr(0, 14'h41, 32'h13); wr(10, 14'h41, 32'h20);
    ex(9, 1, 64'h07, "dis_mid");
    ex(10, 0, 64'h20, "dis_tcfg"); ex(10, 1, 64'h20, "dis_load"); ex(10, 2, 1, "dis_int");
    ex(30, 1, 64'h20, "dis_frozen"); ex(30, 2, 1, "dis_int_hold");
    for (int k = -1; k <= 30; k++) begin
      while (sb.size() > 0 && sb[0].at == k) begin
        e = sb.pop_front();
        total++;
        if (obs(e.sel) !== e.val) begin
          bad++;
          $display("FAIL %s k=%0d got=%h exp=%h", e.nm, k, obs(e.sel), e.val);
        end
      end
      drive(k + 1);
      @(negedge clk);
    end
  endtask
  task automatic test_ignored;
    wr(0, 14'h41, 32'h13); wr(1, 14'h44, 32'h1); wr(3, 14'h42, 32'h5); wr(5, 14'h40, 32'hFFFF_FFFF);
    ex(1, 2, 0, "ign_clr"); ex(1, 1, 64'h0F, "ign_pre");
    ex(3, 1, 64'h0D, "tval_wr_tval"); ex(3, 0, 64'h13, "tval_wr_tcfg"); ex(3, 2, 0, "tval_wr_int");
    ex(5, 1, 64'h0B, "x40_tval"); ex(5, 0, 64'h13, "x40_tcfg"); ex(5, 2, 0, "x40_int");
    ex(16, 1, 0, "ign_zero"); ex(16, 2, 0, "ign_int_pre");
    ex(17, 2, 1, "ign_ti"); ex(17, 1, 64'h10, "ign_reload");
    for (int k = -1; k <= 20; k++) begin
      while (sb.size() > 0 && sb[0].at == k) begin
        e = sb.pop_front();
        total++;
        if (obs(e.sel) !== e.val) begin
          bad++;
          $display("FAIL %s k=%0d got=%h exp=%h", e.nm, k, obs(e.sel), e.val);
        end
      end
      drive(k + 1);
      @(negedge clk);
    end
  endtask
  task automatic test_async_reset;
    #2 resetn = 1'b0;
    #1;
    ex(0, 0, 0, "ar_tcfg"); ex(0, 1, ONES, "ar_tval"); ex(0, 2, 0, "ar_int"); ex(0, 3, 0, "ar_cnt");
    ex(1, 3, 0, "ar_cnt_held");
    for (int k = 0; k <= 1; k++) begin
      while (sb.size() > 0 && sb[0].at == k) begin
        e = sb.pop_front();
        total++;
        if (obs(e.sel) !== e.val) begin
          bad++;
          $display("FAIL %s k=%0d got=%h exp=%h", e.nm, k, obs(e.sel), e.val);
        end
      end
      if (k == 0) @(negedge clk);
    end
    resetn = 1'b1;
    ex(1, 3, 1, "ar_cnt1"); ex(2, 3, 2, "ar_cnt2"); ex(2, 1, ONES, "ar_tval_idle");
    for (int k = 0; k <= 2; k++) begin
      while (sb.size() > 0 && sb[0].at == k) begin
        e = sb.pop_front();
        total++;
        if (obs(e.sel) !== e.val) begin
          bad++;
          $display("FAIL %s k=%0d got=%h exp=%h", e.nm, k, obs(e.sel), e.val);
        end
      end
      drive(k + 1);
      @(negedge clk);
    end
  endtask
  initial begin
    #32 resetn = 1'b1;
    #1;
    test_reset;
    test_periodic;
    test_oneshot;
    test_disable;
    test_ignored;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
